dram16_fifo: RTL and testbench
==============================

// Module: dram16_fifo
// PURPOSE
//   16-deep, WIDTH-bit synchronous FIFO controller sequencing a bank of 16x1 dual-port
//   distributed RAM cells (one cell per data bit). Write pointer drives the A3..A0 port,
//   read pointer drives DPRA3..DPRA0. Read data is first-word-fall-through from DPO.
//   Used as a small rate-matching buffer between RISC5 peripherals (UART/SPI) and the bus.
// PARAMETERS
//   WIDTH     8    data width = number of 16x1 RAM cells in the bank
//   AFULL_LVL 12   almost_full asserts when count >= AFULL_LVL (legal range 1..16)
// PORTS
//   clk          in   1      single clock; all state changes on posedge clk
//   rst          in   1      synchronous, active-high reset
//   flush        in   1      synchronous clear of pointers/count; RAM contents untouched
//   wr_en        in   1      push request
//   wr_data      in   WIDTH  push data
//   rd_en        in   1      pop request (acknowledges current rd_data)
//   rd_data      out  WIDTH  head entry, combinational from RAM DPO at rd_ptr
//   empty        out  1      count == 0
//   full         out  1      count == 16
//   almost_full  out  1      count >= AFULL_LVL
//   count        out  5      occupancy 0..16
//   ovf          out  1      sticky: push attempted while full
//   udf          out  1      sticky: pop attempted while empty
// BEHAVIOUR
//   - State: wr_ptr[3:0], rd_ptr[3:0], count[4:0], ovf, udf; all registered.
//   - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, ovf=udf=0 -> empty=1, full=0,
//     almost_full=0. rd_data undefined while empty. rst overrides flush and all requests.
//   - flush=1 (rst=0): pointers and count to 0; ovf/udf keep value; wr_en/rd_en ignored.
//   - push_ok = wr_en & ~full; pop_ok = rd_en & ~empty (evaluated on pre-edge state).
//   - push_ok: RAM WE=1, D=wr_data at wr_ptr; wr_ptr <= wr_ptr+1 (mod 16, wraps 15->0).
//   - pop_ok: rd_ptr <= rd_ptr+1 (mod 16). rd_data shows the new head after the edge.
//   - count: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
//   - Full + wr_en + rd_en: pop accepted, push rejected, ovf<=1 (no pass-through).
//   - Empty + rd_en + wr_en: push accepted, pop rejected, udf<=1; entry visible on
//     rd_data one cycle after the push edge (write latency 1, read latency 0).
//   - Full state: wr_ptr==rd_ptr; write is blocked so DPO never sees a same-address write.
//   - ovf/udf clear only on rst.
//   - Flags derived combinationally from count register only (no request-path logic).
// STRUCTURE
//   - Shared package/header fifo_defs: DEPTH=16, AW=4, CW=5 constants.
//   - Sub-module dram16_bank: WIDTH x RAM16X1D generate loop; ports clk, we, wa[3:0],
//     wd[WIDTH-1:0], ra[3:0], rd[WIDTH-1:0]. INIT=16'h0000 per cell.
//   - Top: pointer/count/flag registers plus one dram16_bank instance.
// TESTING
//   1 Reset: rst=1 two cycles -> empty=1, full=0, count=0, ovf=0, udf=0.
//   2 Push 8'hA5,8'h3C then pop twice -> rd_data A5 then 3C, count 2->1->0, empty=1.
//   3 Push 16 values 0x00..0x0F -> full=1, count=16, almost_full set at count 12;
//     17th push -> ovf=1, count stays 16; pop all -> 0x00..0x0F in order.
//   4 Wrap: 10 push/10 pop, then 16 push/16 pop -> data intact across 15->0 wrap.
//   5 Full + wr_en + rd_en -> count 15, ovf=1; empty + both -> count 1, udf=1,
//     rd_data = pushed value next cycle.
//   6 Flush at count 5 -> count 0, empty=1, ovf/udf unchanged; rst mid-burst with
//     wr_en=1 -> count 0 after edge, no write.

Source files
------------

// File: rtl/dram16_fifo_pkg.sv
// Shared sizing constants and pointer helper for the 16-deep distributed-RAM FIFO.
package dram16_fifo_pkg;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 5;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction
endpackage

// File: rtl/dram16_fifo_bank.sv
// WIDTH parallel 16x1 dual-port RAM cells: synchronous write port, asynchronous read port.
module dram16_bank
  import dram16_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic [DEPTH-1:0] cell_q = 16'h0000;

    // one RAM16X1D-style cell: write on A port, DPO reads the DPRA address
    always_ff @(posedge clk) begin
      if (we) begin
        cell_q[wa] <= wd[i];
      end
    end

    assign rd[i] = cell_q[ra];
  end
endmodule

// File: rtl/dram16_fifo.sv
// First-word-fall-through FIFO controller: pointers, occupancy, sticky error flags, RAM bank.
module dram16_fifo
  import dram16_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int AFULL_LVL = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          push_ok_s, pop_ok_s, ram_we_s;

  assign empty       = (count_q == CW'(0));
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AFULL_LVL));
  assign count       = count_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

  // request qualification and next-state computation
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    if (flush) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = CW'(0);
    end else begin
      push_ok_s = wr_en & ~full;
      pop_ok_s  = rd_en & ~empty;
      ovf_d     = ovf_q | (wr_en & full);
      udf_d     = udf_q | (rd_en & empty);
      if (push_ok_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // reset must also suppress the RAM write, since the cells are not cleared by it
  assign ram_we_s = push_ok_s & ~rst;

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  dram16_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .we  (ram_we_s),
    .wa  (wr_ptr_q),
    .wd  (wr_data),
    .ra  (rd_ptr_q),
    .rd  (rd_data)
  );
endmodule

// File: tb/tb_dram16_fifo.sv
// Directed bench for dram16_fifo: queue-based reference model checked every cycle plus literal checks.
module tb_dram16_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, almost_full, ovf, udf;
  logic [4:0] count;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic       m_valid = 1'b0;

  dram16_fifo #(.WIDTH(8), .AFULL_LVL(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .ovf         (ovf),
    .udf         (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // reference model: FIFO semantics on a queue, updated on each rising edge
  always @(posedge clk) begin
    bit m_full, m_empty;
    m_full  = (m_q.size() == 16);
    m_empty = (m_q.size() == 0);
    if (rst) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_valid = 1'b1;
    end else if (flush) begin
      m_q.delete();
    end else begin
      if (wr_en && m_full) m_ovf = 1'b1;
      if (rd_en && m_empty) m_udf = 1'b1;
      if (rd_en && !m_empty) void'(m_q.pop_front());
      if (wr_en && !m_full) m_q.push_back(wr_data);
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("count", 32'(count), 32'(m_q.size()));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("full", 32'(full), 32'(m_q.size() == 16));
      chk("almost_full", 32'(almost_full), 32'(m_q.size() >= 12));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("udf", 32'(udf), 32'(m_udf));
      if (m_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
    end
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic f, input logic rs);
    wr_en = w; wr_data = d; rd_en = r; flush = f; rst = rs;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  initial begin
    // 1: reset held two cycles
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_full", 32'(full), 32'd0);
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_ovf", 32'(ovf), 32'd0);
    chk("t1_udf", 32'(udf), 32'd0);

    // 2: two pushes, two pops
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t2_count2", 32'(count), 32'd2);
    chk("t2_head_a5", 32'(rd_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t2_count1", 32'(count), 32'd1);
    chk("t2_head_3c", 32'(rd_data), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t2_count0", 32'(count), 32'd0);
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: fill to 16, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 10) chk("t3_af_at11", 32'(almost_full), 32'd0);
      if (i == 11) chk("t3_af_at12", 32'(almost_full), 32'd1);
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count16", 32'(count), 32'd16);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("t3_ovf", 32'(ovf), 32'd1);
    chk("t3_count_hold", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", 32'(rd_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("t3_empty", 32'(empty), 32'd1);

    // 4: pointer wrap across 15 -> 0
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t4_a", 32'(rd_data), 32'(8'h40 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    chk("t4_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t4_b", 32'(rd_data), 32'(8'h80 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // 5: simultaneous requests at full and at empty
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    chk("t5_ovf_pre", 32'(ovf), 32'd0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("t5_count15", 32'(count), 32'd15);
    chk("t5_ovf", 32'(ovf), 32'd1);
    chk("t5_head", 32'(rd_data), 32'h21);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t5_udf_pre", 32'(udf), 32'd0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("t5_count1", 32'(count), 32'd1);
    chk("t5_udf", 32'(udf), 32'd1);
    chk("t5_fwft", 32'(rd_data), 32'h77);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 6: flush keeps sticky flags; reset during a write burst writes nothing
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    chk("t6_count5", 32'(count), 32'd5);
    cyc(1'b1, 8'hDD, 1'b1, 1'b1, 1'b0);
    chk("t6_flush_count", 32'(count), 32'd0);
    chk("t6_flush_empty", 32'(empty), 32'd1);
    chk("t6_flush_ovf", 32'(ovf), 32'd1);
    chk("t6_flush_udf", 32'(udf), 32'd1);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_ovf", 32'(ovf), 32'd0);
    chk("t6_rst_udf", 32'(udf), 32'd0);
    // flush and reset leave RAM intact, so location 0 still holds 5A
    chk("t6_no_write", 32'(rd_data), 32'h5A);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
